// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM application-interface arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W = 22;

  // Watchdog terminal value used when the timeout feature is built in.
  localparam logic [19:0] WDOG_LIMIT = 20'hFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_READ    = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_rr_pick.sv
// Two-requester round-robin chooser: on a tie the port that was not granted
// last wins; a lone requester always wins.
module sdram_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

  // Pick the winning port index from the current requests.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11)
      winner = ~last_grant;
    else if (req[1])
      winner = 1'b1;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM core application interface between
// two requester ports. Each grant covers a whole transfer of LEN words.
// Optional watchdog: define SDRAM_ARB_TIMEOUT_EN to build the 20-bit stall
// timer and the sticky arb_error flag; otherwise arb_error is tied low.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int LEN_W        = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdram_ready,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [LEN_W-1:0]  p0_len,
  input  logic [LEN_W-1:0]  p1_len,
  input  logic              p0_wr_pulse,
  input  logic              p1_wr_pulse,
  input  logic [31:0]       p0_wr_data,
  input  logic [31:0]       p1_wr_data,
  input  logic [3:0]        p0_wr_mask,
  input  logic [3:0]        p1_wr_mask,
  input  logic              p0_rd_pulse,
  input  logic              p1_rd_pulse,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_done,
  output logic              p1_done,
  output logic              app_write_enable,
  output logic              app_read_enable,
  output logic [ADDR_W-1:0] app_address,
  output logic              app_write_pulse,
  output logic [31:0]       app_write_data,
  output logic [3:0]        app_write_mask,
  output logic              app_read_pulse,
  input  logic              write_fifo_full,
  input  logic              write_fifo_empty,
  input  logic              read_fifo_empty,
  output logic              arb_error
);

  // DRAIN_CYCLES is expected to be at least 1; the counter holds DRAIN_CYCLES-1.
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  arb_state_t          state;
  logic                owner;
  logic                last_grant;
  logic [LEN_W-1:0]    count;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                empty_seen;
  logic                winner;
  logic [1:0]          req_vec;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic                busy;
  logic                xfer_end;
  logic                timeout_hit;

  assign req_vec = {p1_req, p0_req};
  assign busy    = (state == ST_WRITE) || (state == ST_DRAIN) || (state == ST_READ);

  sdram_rr_pick u_pick (
    .req        (req_vec),
    .last_grant (last_grant),
    .winner     (winner)
  );

  // Route the granted port onto the core; an ungranted port sees nothing.
  always_comb begin
    app_write_pulse = 1'b0;
    app_read_pulse  = 1'b0;
    app_write_data  = '0;
    app_write_mask  = '0;
    if (p0_gnt) begin
      app_write_pulse = p0_wr_pulse & ~write_fifo_full;
      app_read_pulse  = p0_rd_pulse & ~read_fifo_empty;
      app_write_data  = p0_wr_data;
      app_write_mask  = p0_wr_mask;
    end else if (p1_gnt) begin
      app_write_pulse = p1_wr_pulse & ~write_fifo_full;
      app_read_pulse  = p1_rd_pulse & ~read_fifo_empty;
      app_write_data  = p1_wr_data;
      app_write_mask  = p1_wr_mask;
    end
  end

  // Select the winning port's transfer descriptor and flag normal completion.
  always_comb begin
    sel_we   = winner ? p1_we   : p0_we;
    sel_addr = winner ? p1_addr : p0_addr;
    sel_len  = winner ? p1_len  : p0_len;
    xfer_end = ((state == ST_DRAIN) && empty_seen && (drain_cnt == '0)) ||
               ((state == ST_READ) && app_read_pulse && (count == '0));
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [19:0] wdog;

  assign timeout_hit = busy && (wdog == WDOG_LIMIT);

  // Stall watchdog: restarts on every accepted word, runs while a transfer is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog      <= '0;
      arb_error <= 1'b0;
    end else begin
      if (!busy || app_write_pulse || app_read_pulse)
        wdog <= '0;
      else
        wdog <= wdog + 20'd1;
      if (timeout_hit)
        arb_error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign arb_error   = 1'b0;
`endif

  // Arbitration FSM with registered grant, enables, address and done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      owner            <= 1'b0;
      last_grant       <= 1'b1;
      count            <= '0;
      drain_cnt        <= '0;
      empty_seen       <= 1'b0;
      p0_gnt           <= 1'b0;
      p1_gnt           <= 1'b0;
      p0_done          <= 1'b0;
      p1_done          <= 1'b0;
      app_write_enable <= 1'b0;
      app_read_enable  <= 1'b0;
      app_address      <= '0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      if (busy && (!sdram_ready || timeout_hit || xfer_end)) begin
        p0_gnt           <= 1'b0;
        p1_gnt           <= 1'b0;
        app_write_enable <= 1'b0;
        app_read_enable  <= 1'b0;
        app_address      <= '0;
        last_grant       <= owner;
        if (!sdram_ready) begin
          state <= ST_IDLE;
        end else begin
          state <= ST_RELEASE;
          if (!timeout_hit) begin
            p0_done <= ~owner;
            p1_done <= owner;
          end
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (sdram_ready && (req_vec != 2'b00)) begin
              owner       <= winner;
              p0_gnt      <= ~winner;
              p1_gnt      <= winner;
              app_address <= sel_addr;
              count       <= (sel_len == '0) ? '0 : sel_len - LEN_W'(1);
              empty_seen  <= 1'b0;
              if (sel_we) begin
                state            <= ST_WRITE;
                app_write_enable <= 1'b1;
              end else begin
                state           <= ST_READ;
                app_read_enable <= 1'b1;
              end
            end
          end
          ST_WRITE: begin
            if (app_write_pulse) begin
              if (count == '0)
                state <= ST_DRAIN;
              else
                count <= count - LEN_W'(1);
            end
          end
          ST_DRAIN: begin
            if (!empty_seen) begin
              if (write_fifo_empty) begin
                empty_seen <= 1'b1;
                drain_cnt  <= DRAIN_W'(DRAIN_CYCLES - 1);
              end
            end else begin
              drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
          end
          ST_READ: begin
            if (app_read_pulse)
              count <= count - LEN_W'(1);
          end
          ST_RELEASE: state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
